// File: rtl/adc_scan_spi.sv
// Channel sweep sequencer and SPI master for the 8-channel 12-bit board ADC.
// Optional macro ADC_TRIG_EN: one sweep per accepted `trig` instead of free-running sweeps.
module adc_scan_spi #(
  parameter int unsigned SCLK_HALF = 8,
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned CS_GAP    = 8
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        enable,
`ifdef ADC_TRIG_EN
  input  logic        trig,
`endif
  output logic        ADC_CS_N,
  output logic        ADC_SADDR,
  output logic        ADC_SCLK,
  input  logic        ADC_SDAT,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        busy,
  output logic        sweep_done
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

  localparam logic [15:0] HALF_LAST  = 16'(SCLK_HALF - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
  localparam logic [3:0]  LAST_FRAME = 4'(NUM_CH);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  bit_q;
  logic [3:0]  frame_q;
  logic        phase_q;
  logic [11:0] shift_q;
  logic        cs_n_q, sclk_q, saddr_q;
  logic        valid_q, done_q, busy_q;
  logic [11:0] data_q;
  logic [2:0]  ch_q;

  logic        start;
  logic [2:0]  addr;
  logic [3:0]  nxt_bit;
  logic        saddr_d;

`ifdef ADC_TRIG_EN
  assign start = trig && enable;
`else
  assign start = enable;
`endif

  // The last frame of a sweep addresses channel 0 only to flush the ADC pipeline.
  assign addr = (frame_q == LAST_FRAME) ? 3'd0 : frame_q[2:0];

  always_comb begin
    nxt_bit = (state_q == SHIFT) ? bit_q + 4'd1 : 4'd0;
    saddr_d = 1'b0;
    case (nxt_bit)
      4'd2:    saddr_d = addr[2];
      4'd3:    saddr_d = addr[1];
      4'd4:    saddr_d = addr[0];
      default: saddr_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      saddr_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b1;
          saddr_q <= 1'b0;
          cnt_q   <= '0;
          if (start) begin
            state_q <= CS_SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            frame_q <= '0;
          end
        end
        CS_SETUP: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
            sclk_q  <= 1'b0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            saddr_q <= saddr_d;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SHIFT: begin
          // Fires one cycle after the 16th rising SCLK, once the last bit is in shift_q.
          if (phase_q && cnt_q == '0 && bit_q == 4'd15 && frame_q != '0) begin
            valid_q <= 1'b1;
            data_q  <= shift_q;
            ch_q    <= 3'(frame_q - 4'd1);
            done_q  <= (frame_q == LAST_FRAME);
          end
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!phase_q) begin
              phase_q <= 1'b1;
              sclk_q  <= 1'b1;
              shift_q <= {shift_q[10:0], ADC_SDAT};
            end else if (bit_q == 4'd15) begin
              state_q <= CS_HOLD;
            end else begin
              phase_q <= 1'b0;
              sclk_q  <= 1'b0;
              bit_q   <= nxt_bit;
              saddr_q <= saddr_d;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        CS_HOLD: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (frame_q != LAST_FRAME) begin
              frame_q <= frame_q + 4'd1;
              state_q <= CS_SETUP;
              cs_n_q  <= 1'b0;
            end else begin
`ifdef ADC_TRIG_EN
              state_q <= IDLE;
              busy_q  <= 1'b0;
`else
              if (enable) begin
                frame_q <= '0;
                state_q <= CS_SETUP;
                cs_n_q  <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
`endif
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ADC_CS_N     = cs_n_q;
  assign ADC_SCLK     = sclk_q;
  assign ADC_SADDR    = saddr_q;
  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign busy         = busy_q;
  assign sweep_done   = done_q;

endmodule

// File: tb/tb_adc_scan_spi.sv
// Bench for adc_scan_spi: ADC pin model, frame/address monitor and sample scoreboard.
`timescale 1ns/1ps
module tb_adc_scan_spi;
  localparam int H    = 8;
  localparam int NCH  = 8;
  localparam int GAPC = 8;
  localparam int FLEN = 34 * H;
  localparam int FPER = FLEN + GAPC;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
    logic        done;
  } exp_t;

  typedef struct {
    logic [11:0] adc_word;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        enable = 1'b0;
`ifdef ADC_TRIG_EN
  logic        trig = 1'b0;
`endif
  logic        ADC_CS_N, ADC_SADDR, ADC_SCLK;
  logic        ADC_SDAT = 1'b0;
  logic        sample_valid, busy, sweep_done;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  vec_t vecs[16];
  exp_t sb[$];

  logic [11:0] tbl[8];
  int   fidx = 8, sweep_no = 0, n_falls = 0, n_done = 0;
  int   last_fall = 0, low_start = 0, rise16 = 0, rises = 0, nsf = 0;
  bit   last_fall_ok = 0, in_frame = 0, saddr_bad = 0, expect_b2b = 0;
  logic [15:0] addr_bits = '0;
  logic [11:0] word = '0;
  logic [2:0]  conv_ch = '0;
  logic cs_prev = 1'b1, sclk_prev = 1'b1, saddr_prev = 1'b0, valid_prev = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  adc_scan_spi #(.SCLK_HALF(H), .NUM_CH(NCH), .CS_GAP(GAPC)) dut (
    .CLOCK_50     (clk),
    .RESET_N      (RESET_N),
    .enable       (enable),
`ifdef ADC_TRIG_EN
    .trig         (trig),
`endif
    .ADC_CS_N     (ADC_CS_N),
    .ADC_SADDR    (ADC_SADDR),
    .ADC_SCLK     (ADC_SCLK),
    .ADC_SDAT     (ADC_SDAT),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .busy         (busy),
    .sweep_done   (sweep_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_sweep();
    tick();
    enable = 1'b1;
`ifdef ADC_TRIG_EN
    trig = 1'b1;
`endif
    @(posedge clk);
    #2;
`ifdef ADC_TRIG_EN
    trig = 1'b0;
`endif
    @(negedge clk);
    check("start_latency", 32'({ADC_CS_N, busy}), 32'(2'b01));
  endtask

  // ADC model plus frame, address and sample monitors, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!RESET_N) begin
      sb.delete();
      fidx = 8; sweep_no = 0; n_falls = 0; n_done = 0;
      last_fall_ok = 0; in_frame = 0; ADC_SDAT = 1'b0;
      for (int c = 0; c < 8; c++) tbl[c] = '0;
    end else begin
      if (cs_prev && !ADC_CS_N) begin
        fidx = (fidx == NCH) ? 0 : fidx + 1;
        n_falls++;
        if (fidx == 0) begin
          sweep_no++;
          for (int c = 0; c < 8; c++) begin
            tbl[c] = vecs[((sweep_no - 1) % 2) * 8 + c].adc_word;
            sb.push_back(vecs[((sweep_no - 1) % 2) * 8 + c].exp);
          end
        end
        if (last_fall_ok && (fidx != 0 || expect_b2b))
          check("frame_period", 32'(cyc - last_fall), 32'(FPER));
        last_fall = cyc; last_fall_ok = 1; low_start = cyc; in_frame = 1;
        rises = 0; nsf = 0; addr_bits = '0; saddr_bad = 0;
        word = tbl[conv_ch];
      end
      if (in_frame && sclk_prev && !ADC_SCLK) begin
        nsf++;
        ADC_SDAT = (nsf <= 4) ? 1'b1 : word[16 - nsf];
      end
      if (in_frame && !sclk_prev && ADC_SCLK) begin
        rises++;
        addr_bits = {addr_bits[14:0], ADC_SADDR};
        if (rises == 16) rise16 = cyc;
      end
      if (ADC_SADDR !== saddr_prev && !(sclk_prev && !ADC_SCLK)) saddr_bad = 1;
      if (in_frame && !cs_prev && ADC_CS_N) begin
        in_frame = 0;
        check("frame_len", 32'(cyc - low_start), 32'(FLEN));
        check("saddr_frame", 32'({saddr_bad, 15'(rises), addr_bits}),
              32'({1'b0, 15'd16, (fidx == NCH) ? 16'h0 : 16'(fidx << 11)}));
        conv_ch = addr_bits[13:11];
      end
      if (sweep_done) check("done_with_valid", 32'(sample_valid), 32'd1);
      if (sample_valid) begin
        exp_t e;
        check("valid_single", 32'(valid_prev), 32'd0);
        check("valid_latency", 32'(cyc - rise16), 32'd1);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_valid: got ch %0d data 0x%0h, want none", sample_ch, sample_data);
        end else begin
          e = sb.pop_front();
          check("sample", 32'({sweep_done, sample_ch, sample_data}), 32'({e.done, e.ch, e.data}));
        end
        if (sweep_done) n_done++;
      end
    end
    cs_prev = ADC_CS_N; sclk_prev = ADC_SCLK; saddr_prev = ADC_SADDR; valid_prev = sample_valid;
  end

  initial begin
    logic [11:0] wb[8];
    wb[0] = 12'hFFF; wb[1] = 12'h000; wb[2] = 12'hA5C; wb[3] = 12'h800;
    wb[4] = 12'h001; wb[5] = 12'h7FE; wb[6] = 12'h555; wb[7] = 12'hAAA;
    for (int c = 0; c < 8; c++) begin
      vecs[c].adc_word     = 12'(12'h100 + c);
      vecs[c].exp.ch       = 3'(c);
      vecs[c].exp.data     = 12'(12'h100 + c);
      vecs[c].exp.done     = (c == 7);
      vecs[8 + c].adc_word = wb[c];
      vecs[8 + c].exp.ch   = 3'(c);
      vecs[8 + c].exp.data = wb[c];
      vecs[8 + c].exp.done = (c == 7);
    end

    repeat (3) tick();
    @(negedge clk);
    check("rst_pins", 32'({ADC_CS_N, ADC_SCLK, ADC_SADDR}), 32'(3'b110));
    check("rst_strobes", 32'({sample_valid, sweep_done, busy}), 32'd0);
    check("rst_data", 32'({sample_ch, sample_data}), 32'd0);
    tick();
    RESET_N = 1'b1;

    // Abort a sweep mid-frame 1, before its first sample is delivered.
    start_sweep();
    repeat (380) tick();
    RESET_N = 1'b0;
    enable  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("rst_hold", 32'({ADC_CS_N, ADC_SCLK, ADC_SADDR, sample_valid, busy}), 32'(5'b11000));
    end
    tick();
    RESET_N = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst", 32'({ADC_CS_N, ADC_SCLK, busy, sample_data}), 32'({3'b110, 12'h000}));

`ifdef ADC_TRIG_EN
    start_sweep();
    for (int i = 0; i < 2000 && !(sweep_no == 1 && fidx == 2); i++) tick();
    check("reach_frame2", 32'({sweep_no == 1, fidx == 2}), 32'(2'b11));
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 4000 && busy; i++) tick();
    check("busy_drop1", 32'(busy), 32'd0);
    repeat (600) tick();
    check("one_sweep_frames", 32'(n_falls), 32'd9);
    start_sweep();
    for (int i = 0; i < 4000 && busy; i++) tick();
    check("busy_drop2", 32'(busy), 32'd0);
    repeat (1000) tick();
    check("frames_total", 32'(n_falls), 32'd18);
    check("sweep_dones", 32'(n_done), 32'd2);
`else
    expect_b2b = 1;
    start_sweep();
    for (int i = 0; i < 12000 && !(sweep_no == 3 && fidx == 3); i++) tick();
    check("reach_frame3", 32'({sweep_no == 3, fidx == 3}), 32'(2'b11));
    enable = 1'b0;
    expect_b2b = 0;
    for (int i = 0; i < 4000 && busy; i++) tick();
    check("busy_drop", 32'(busy), 32'd0);
    check("frames_total", 32'(n_falls), 32'd27);
    check("sweep_dones", 32'(n_done), 32'd3);
    repeat (1000) tick();
    check("no_more_frames", 32'(n_falls), 32'd27);
`endif
    @(negedge clk);
    check("idle_pins", 32'({ADC_CS_N, ADC_SCLK, busy}), 32'(3'b110));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
